door_lock_ctrl: RTL and testbench

Keypad-driven electronic door lock controller. It collects a 4-digit code entered one BCD digit at a time, compares it against a fixed code and unlocks the door for a bounded time before auto-relocking. Repeated wrong codes raise a timed alarm. Top-level block driving the lock actuator, the red/green status LEDs and the alarm sounder.

---
 rtl/door_lock_ctrl.sv | 137 +++++++++++++
 tb/tb_door_lock_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/door_lock_ctrl.sv
// Keypad door lock: collects four BCD digits, unlocks for a bounded time on a
// code match, and raises a timed alarm after repeated wrong codes.
module door_lock_ctrl #(
  parameter logic [3:0]  CODE0         = 4'd2,
  parameter logic [3:0]  CODE1         = 4'd2,
  parameter logic [3:0]  CODE2         = 4'd3,
  parameter logic [3:0]  CODE3         = 4'd4,
  parameter int unsigned UNLOCK_CYCLES = 400000,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned ALARM_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       enter,
  output logic       locked,
  output logic       red_light,
  output logic       green_light,
  output logic       alarm
);

  localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > ALARM_CYCLES) ? UNLOCK_CYCLES : ALARM_CYCLES;
  // Timers load CYCLES-1 and count down to zero, so $clog2 of the larger count suffices.
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned FW      = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] buf_q, buf_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            enter_q;
  logic            locked_q, locked_d;
  logic            red_q, red_d;
  logic            green_q, green_d;
  logic            alarm_q, alarm_d;
  logic            digit_evt;

  assign digit_evt = enter & ~enter_q;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LOCKED;
      idx_q    <= '0;
      buf_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      enter_q  <= 1'b0;
      locked_q <= 1'b1;
      red_q    <= 1'b1;
      green_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      enter_q  <= enter;
      locked_q <= locked_d;
      red_q    <= red_d;
      green_q  <= green_d;
      alarm_q  <= alarm_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    locked_d = (state_q != ST_UNLOCKED);
    red_d    = (state_q != ST_UNLOCKED);
    green_d  = (state_q == ST_UNLOCKED);
    alarm_d  = (state_q == ST_ALARM);

    case (state_q)
      ST_LOCKED: begin
        if (digit_evt) begin
          buf_d[idx_q] = key_in;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_CHECK: begin
        if (buf_q == {CODE3, CODE2, CODE1, CODE0}) begin
          state_d = ST_UNLOCKED;
          fail_d  = '0;
          timer_d = TW'(UNLOCK_CYCLES - 1);
        end else if ((32'(fail_q) + 32'd1) < MAX_FAILS) begin
          state_d = ST_LOCKED;
          fail_d  = fail_q + FW'(1);
        end else begin
          state_d = ST_ALARM;
          fail_d  = '0;
          timer_d = TW'(ALARM_CYCLES - 1);
        end
      end
      ST_UNLOCKED: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          buf_d   = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_ALARM: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  assign locked      = locked_q;
  assign red_light   = red_q;
  assign green_light = green_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: event-window reference model checked every cycle,
// plus directed literal expectations on key scenarios.
module tb_door_lock_ctrl;

  localparam int unsigned U  = 40;
  localparam int unsigned A  = 60;
  localparam int unsigned MF = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enter = 1'b0;
  logic [3:0] key_in = 4'd0;
  logic       locked, red_light, green_light, alarm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  door_lock_ctrl #(
    .CODE0(4'd2), .CODE1(4'd2), .CODE2(4'd3), .CODE3(4'd4),
    .UNLOCK_CYCLES(U), .MAX_FAILS(MF), .ALARM_CYCLES(A)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .enter(enter),
    .locked(locked), .red_light(red_light), .green_light(green_light), .alarm(alarm)
  );

  // Reference model: absolute edge count plus the visible green/alarm windows
  // and the first edge at which new digits are accepted again.
  int  cyc = 0;
  bit  prev_en = 1'b0;
  int  q[$];
  int  fails = 0;
  int  gf = -1, gt = -2, af = -1, at = -2, acc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      fails = 0;
      gf = -1; gt = -2; af = -1; at = -2;
      acc = 0;
      prev_en = 1'b0;
    end else begin
      bit evt;
      cyc++;
      evt = enter && !prev_en;
      prev_en = enter;
      if (evt && cyc >= acc) begin
        q.push_back(int'(key_in));
        if (q.size() == 4) begin
          if (q[0] == 2 && q[1] == 2 && q[2] == 3 && q[3] == 4) begin
            fails = 0;
            gf  = cyc + 2;
            gt  = cyc + 1 + int'(U);
            acc = cyc + 2 + int'(U);
          end else begin
            fails++;
            if (fails == int'(MF)) begin
              fails = 0;
              af  = cyc + 2;
              at  = cyc + 1 + int'(A);
              acc = cyc + 2 + int'(A);
            end else begin
              acc = cyc + 2;
            end
          end
          q.delete();
        end
      end
    end
  end

  function automatic bit m_green();
    return (cyc >= gf) && (cyc <= gt);
  endfunction

  function automatic bit m_alarm();
    return (cyc >= af) && (cyc <= at);
  endfunction

  // Per-cycle comparison of all four outputs against the model.
  always @(posedge clk) begin
    logic [3:0] got, exp;
    #2;
    got = {locked, red_light, green_light, alarm};
    exp = {~m_green(), ~m_green(), m_green(), m_alarm()};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t cyc=%0d {locked,red,green,alarm} got %b exp %b",
               $time, cyc, got, exp);
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b exp %b", name, $time, got, exp);
    end
  endtask

  task automatic chk_locked(input string name);
    chk({name, "_locked"}, locked, 1'b1);
    chk({name, "_red"}, red_light, 1'b1);
    chk({name, "_green"}, green_light, 1'b0);
  endtask

  task automatic chk_open(input string name);
    chk({name, "_locked"}, locked, 1'b0);
    chk({name, "_green"}, green_light, 1'b1);
    chk({name, "_model_green"}, m_green(), 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_in = k;
    enter  = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    logic [3:0] seq [4];
    seq[0] = 4'd2; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd4;
    rst = 1'b0;

    // Reset state, held and released.
    idle(2);
    chk_locked("reset");
    chk("reset_alarm", alarm, 1'b0);
    rst = 1'b1;
    idle(2);
    chk_locked("release");
    chk("release_alarm", alarm, 1'b0);

    // Correct code with exact two-edge latency after the 4th digit event.
    press(4'd2); press(4'd2); press(4'd3);
    @(negedge clk); key_in = 4'd4; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    chk("lat_edge0_locked", locked, 1'b1);
    @(negedge clk);
    chk("lat_edge1_locked", locked, 1'b1);
    @(negedge clk);
    chk_open("lat_edge2");
    idle(10);
    chk_open("still_open");
    idle(int'(U) + 5);
    chk_locked("relock");
    chk("relock_model_green", m_green(), 1'b0);

    // Wrong code, then correct code clears the fail count.
    enter_code(4'd2, 4'd2, 4'd3, 4'd5);
    chk_locked("wrong");
    chk("wrong_alarm", alarm, 1'b0);
    enter_code(4'd2, 4'd2, 4'd3, 4'd4);
    chk_open("after_wrong");
    idle(int'(U) + 5);

    // Three wrong codes raise the alarm; correct code during alarm is ignored.
    enter_code(4'd1, 4'd1, 4'd1, 4'd1);
    enter_code(4'd1, 4'd1, 4'd1, 4'd1);
    chk("two_wrong_alarm", alarm, 1'b0);
    enter_code(4'd1, 4'd1, 4'd1, 4'd1);
    chk("alarm_on", alarm, 1'b1);
    chk("alarm_locked", locked, 1'b1);
    chk("alarm_model", m_alarm(), 1'b1);
    enter_code(4'd2, 4'd2, 4'd3, 4'd4);
    chk("alarm_ignore", alarm, 1'b1);
    chk_locked("alarm_ignore");
    idle(int'(A));
    chk("alarm_off", alarm, 1'b0);
    enter_code(4'd2, 4'd2, 4'd3, 4'd4);
    chk_open("post_alarm");
    idle(int'(U) + 5);

    // Held enter counts as a single digit.
    @(negedge clk); key_in = 4'd2; enter = 1'b1;
    idle(10);
    enter = 1'b0;
    idle(3);
    press(4'd2); press(4'd3); press(4'd4);
    chk_open("held");
    idle(int'(U) + 5);

    // Reset mid-entry discards the partial code.
    @(negedge clk); key_in = 4'd2; enter = 1'b1;
    idle(10);
    enter = 1'b0;
    idle(3);
    press(4'd2);
    rst = 1'b0;
    idle(1);
    chk_locked("mid_reset");
    rst = 1'b1;
    press(4'd3); press(4'd4);
    chk_locked("partial");
    press(4'd2); press(4'd2);
    chk_locked("misaligned");
    enter_code(4'd2, 4'd2, 4'd3, 4'd4);
    chk_open("after_reset");

    // Digit events keep arriving through the unlocked period and its end.
    for (int i = 0; i < 12; i++) press(seq[i % 4]);
    idle(int'(U) + 5);

    // Out-of-range keys never match.
    enter_code(4'd15, 4'd2, 4'd3, 4'd4);
    chk_locked("key15");
    idle(int'(A) + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
